// File: rtl/vdp_bus_pkg.sv
// vdp_bus_pkg: shared region codes, FSM states and address decode for the VDP bus front end.
package vdp_bus_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] RGN_NONE = 2'd0;
    localparam logic [1:0] RGN_CNT  = 2'd1;
    localparam logic [1:0] RGN_VDP  = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    function automatic logic [1:0] decode_rgn(input logic [7:0] a);
        return (a[7:6] == 2'b01) ? RGN_CNT : (a[7:6] == 2'b10) ? RGN_VDP : RGN_NONE;
    endfunction

endpackage

// File: rtl/vdp_bus_if_sync_ff.sv
// sync_ff: SYNC_STAGES-deep multi-bit synchroniser with a configurable reset value.
module sync_ff
    import vdp_bus_pkg::*;
#(
    parameter int W = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [SYNC_STAGES*W-1:0] sh;

    always_ff @(posedge clk or posedge reset)
        if (reset) sh <= {SYNC_STAGES{RST}};
        else       sh <= {sh[(SYNC_STAGES-1)*W-1:0], d};

    assign q = sh[SYNC_STAGES*W-1 -: W];

endmodule

// File: rtl/vdp_bus_if.sv
// vdp_bus_if: Z80 I/O cycle decoder producing single-cycle register pulses for the VDP.
// Define VDP_HVCNT_EN to include the H/V counter synchroniser and snapshot.
module vdp_bus_if
    import vdp_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_addr,
    input  logic       bus_iorq_n,
    input  logic       bus_rd_n,
    input  logic       bus_wr_n,
    input  logic [7:0] bus_wrdata,
    output logic [7:0] bus_rddata,
    output logic       bus_rden,
    output logic       io_portsel,
    output logic [7:0] io_wrdata,
    output logic       io_wren,
    output logic       io_wrdone,
    output logic       io_rddone,
    input  logic [7:0] io_rddata,
    output logic       psg_wren,
    input  logic [7:0] vcnt,
    input  logic [7:0] hcnt
);

    logic       s_iorq, s_rd, s_wr;
    logic       wr_act, rd_act;
    logic [1:0] rgn, rgn_q;
    logic [7:0] cnt_byte, cnt_q;
    logic       armed;
    state_t     state;

    // Strobes reset to "active" so an access in flight across reset is never seen as a fresh edge.
    sync_ff #(.W(3), .RST(3'b111)) u_strb (
        .clk  (clk),
        .reset(reset),
        .d    ({~bus_iorq_n, ~bus_rd_n, ~bus_wr_n}),
        .q    ({s_iorq, s_rd, s_wr})
    );

    assign wr_act = s_iorq & s_wr & ~s_rd;
    assign rd_act = s_iorq & s_rd & ~s_wr;
    assign rgn    = decode_rgn(bus_addr);

`ifdef VDP_HVCNT_EN
    logic [15:0] hv_s, hv_p, q_hv;
    logic        unused_addr;

    sync_ff #(.W(16), .RST(16'h0000)) u_hv (
        .clk  (clk),
        .reset(reset),
        .d    ({vcnt, hcnt}),
        .q    (hv_s)
    );

    // Only accept a synced value once it has been stable for two samples.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hv_p <= '0;
            q_hv <= '0;
        end else begin
            hv_p <= hv_s;
            if (hv_s == hv_p) q_hv <= hv_s;
        end

    assign cnt_byte    = bus_addr[0] ? q_hv[7:0] : q_hv[15:8];
    assign unused_addr = ^bus_addr[5:1];
`else
    logic unused_hv;

    assign cnt_byte  = 8'hFF;
    assign unused_hv = ^{bus_addr[5:1], vcnt, hcnt};
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            rgn_q      <= RGN_NONE;
            cnt_q      <= 8'hFF;
            bus_rddata <= 8'hFF;
            bus_rden   <= 1'b0;
            io_portsel <= 1'b0;
            io_wrdata  <= 8'h00;
            io_wren    <= 1'b0;
            psg_wren   <= 1'b0;
            io_wrdone  <= 1'b0;
            io_rddone  <= 1'b0;
        end else begin
            io_wren   <= 1'b0;
            psg_wren  <= 1'b0;
            io_wrdone <= 1'b0;
            io_rddone <= 1'b0;
            case (state)
                ST_IDLE:
                    if (!armed) armed <= !s_rd && !s_wr;
                    else if (wr_act && rgn != RGN_NONE) begin
                        state      <= ST_WR;
                        rgn_q      <= rgn;
                        io_wrdata  <= bus_wrdata;
                        io_portsel <= bus_addr[0];
                        io_wren    <= rgn == RGN_VDP;
                        psg_wren   <= rgn == RGN_CNT;
                    end else if (rd_act && rgn != RGN_NONE) begin
                        state      <= ST_RD;
                        rgn_q      <= rgn;
                        cnt_q      <= cnt_byte;
                        io_portsel <= bus_addr[0];
                        bus_rden   <= 1'b1;
                    end
                ST_WR:
                    if (!wr_act) begin
                        state     <= ST_IDLE;
                        io_wrdone <= rgn_q == RGN_VDP;
                    end
                ST_RD: begin
                    bus_rddata <= (rgn_q == RGN_VDP) ? io_rddata : cnt_q;
                    if (!rd_act) begin
                        state     <= ST_IDLE;
                        bus_rden  <= 1'b0;
                        io_rddone <= rgn_q == RGN_VDP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end

endmodule

// File: tb/tb_vdp_bus_if.sv
// tb_vdp_bus_if: directed bench with a pulse scoreboard for vdp_bus_if (works with or without VDP_HVCNT_EN).
module tb_vdp_bus_if;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_iorq_n = 1'b1, bus_rd_n = 1'b1, bus_wr_n = 1'b1;
    logic [7:0] bus_wrdata = 8'h00;
    logic [7:0] bus_rddata;
    logic       bus_rden;
    logic       io_portsel;
    logic [7:0] io_wrdata;
    logic       io_wren, io_wrdone, io_rddone, psg_wren;
    logic [7:0] io_rddata = 8'h00;
    logic [7:0] vcnt = 8'hC0, hcnt = 8'h11;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  data;
        logic [31:0] cyc;
    } ev_t;

    localparam logic [1:0] K_WREN = 2'd0, K_PSG = 2'd1, K_WRDONE = 2'd2, K_RDDONE = 2'd3;

    ev_t         sb[$];
    logic [31:0] cyc = 0;
    int          n_asrt = 0;
    int          n_fail = 0;

    vdp_bus_if dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_iorq_n(bus_iorq_n),
        .bus_rd_n  (bus_rd_n),
        .bus_wr_n  (bus_wr_n),
        .bus_wrdata(bus_wrdata),
        .bus_rddata(bus_rddata),
        .bus_rden  (bus_rden),
        .io_portsel(io_portsel),
        .io_wrdata (io_wrdata),
        .io_wren   (io_wren),
        .io_wrdone (io_wrdone),
        .io_rddone (io_rddone),
        .io_rddata (io_rddata),
        .psg_wren  (psg_wren),
        .vcnt      (vcnt),
        .hcnt      (hcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [8:0] d, input logic [31:0] c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Every observed pulse must match the oldest expected event, including its cycle.
    task automatic got(input logic [1:0] k, input logic [8:0] d);
        ev_t e;
        n_asrt++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_pulse: observed kind %0d data %0h at cycle %0d, expected none", k, d, cyc);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pulse_kind_data_cycle", 64'({k, d, cyc}), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (io_wren)   got(K_WREN, {io_portsel, io_wrdata});
        if (psg_wren)  got(K_PSG, {io_portsel, io_wrdata});
        if (io_wrdone) got(K_WRDONE, 9'd0);
        if (io_rddone) got(K_RDDONE, 9'd0);
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int len, input logic [1:0] k, input bit pulse);
        @(negedge clk);
        bus_addr = a;
        bus_wrdata = d;
        bus_iorq_n = 1'b0;
        bus_wr_n = 1'b0;
        if (pulse) push(k, {a[0], d}, cyc + 3);
        repeat (4) @(negedge clk);
        bus_addr = 8'h00;
        bus_wrdata = 8'hEE;
        repeat (len - 4) @(negedge clk);
        bus_iorq_n = 1'b1;
        bus_wr_n = 1'b1;
        if (pulse && k == K_WREN) push(K_WRDONE, 9'd0, cyc + 3);
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] rdv, input logic [7:0] expd, input bit vdp);
        @(negedge clk);
        bus_addr = a;
        io_rddata = rdv;
        bus_iorq_n = 1'b0;
        bus_rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_rden_early"}, 64'(bus_rden), 64'd0);
        @(negedge clk);
        check({tag, "_rden_entry"}, 64'(bus_rden), 64'd1);
        @(negedge clk);
        bus_addr = 8'h00;
        repeat (2) @(negedge clk);
        check({tag, "_rddata"}, 64'(bus_rddata), 64'(expd));
        bus_iorq_n = 1'b1;
        bus_rd_n = 1'b1;
        if (vdp) push(K_RDDONE, 9'd0, cyc + 3);
        repeat (5) @(negedge clk);
        check({tag, "_rden_after"}, 64'(bus_rden), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rddata", 64'(bus_rddata), 64'hFF);
        check("rst_rden", 64'(bus_rden), 64'd0);
        check("rst_portsel", 64'(io_portsel), 64'd0);
        check("rst_wrdata", 64'(io_wrdata), 64'd0);
        check("rst_pulses", 64'({io_wren, io_wrdone, io_rddone, psg_wren}), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        wr(8'hBF, 8'h12, 6, K_WREN, 1'b1);
        check("wr_bf_portsel", 64'(io_portsel), 64'd1);

        rd("rd_be", 8'hBE, 8'hA5, 8'hA5, 1'b1);
        check("rd_be_portsel", 64'(io_portsel), 64'd0);

        wr(8'h7F, 8'h9F, 6, K_PSG, 1'b1);

`ifdef VDP_HVCNT_EN
        rd("rd_7e", 8'h7E, 8'h5A, 8'hC0, 1'b0);
        rd("rd_7f", 8'h7F, 8'h5A, 8'h11, 1'b0);
`else
        rd("rd_7e", 8'h7E, 8'h5A, 8'hFF, 1'b0);
        rd("rd_7f", 8'h7F, 8'h5A, 8'hFF, 1'b0);
`endif

        wr(8'h3E, 8'h77, 6, K_WREN, 1'b0);

        @(negedge clk);
        bus_addr = 8'hBE;
        bus_iorq_n = 1'b0;
        bus_rd_n = 1'b0;
        bus_wr_n = 1'b0;
        repeat (5) @(negedge clk);
        check("both_rden_mid", 64'(bus_rden), 64'd0);
        bus_iorq_n = 1'b1;
        bus_rd_n = 1'b1;
        bus_wr_n = 1'b1;
        repeat (5) @(negedge clk);
        check("both_rden_after", 64'(bus_rden), 64'd0);

        @(negedge clk);
        bus_addr = 8'hBE;
        bus_wrdata = 8'h34;
        bus_iorq_n = 1'b0;
        bus_wr_n = 1'b0;
        push(K_WREN, {1'b0, 8'h34}, cyc + 3);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_wrdata", 64'(io_wrdata), 64'd0);
        check("midrst_rddata", 64'(bus_rddata), 64'hFF);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        bus_iorq_n = 1'b1;
        bus_wr_n = 1'b1;
        repeat (8) @(negedge clk);

        wr(8'hBF, 8'h56, 6, K_WREN, 1'b1);
        check("post_rst_wrdata", 64'(io_wrdata), 64'h56);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
